// File: rtl/dec_key_schedule_128_if.sv
// Start/key load, subkey stream handshake and status signals of the SWAN128 decryption key schedule.
// The selfcheck_err status exists only when DEC_KS_SELFCHECK_EN is defined.
interface dec_key_schedule_128_if;
  logic         start;
  logic [0:127] key_in;
  logic         busy;
  logic         sk_valid;
  logic         sk_ready;
  logic [0:63]  sk;
  logic [5:0]   sk_round;
  logic         done;
`ifdef DEC_KS_SELFCHECK_EN
  logic         selfcheck_err;

  modport master (output start, key_in, sk_ready,
                  input  busy, sk_valid, sk, sk_round, done, selfcheck_err);
  modport slave  (input  start, key_in, sk_ready,
                  output busy, sk_valid, sk, sk_round, done, selfcheck_err);
`else
  modport master (output start, key_in, sk_ready,
                  input  busy, sk_valid, sk, sk_round, done);
  modport slave  (input  start, key_in, sk_ready,
                  output busy, sk_valid, sk, sk_round, done);
`endif
endinterface

// File: rtl/dec_key_schedule_128.sv
// SWAN128 decryption key schedule: runs the encryption schedule forward, then emits subkeys ROUNDS..1 by inverse steps.
// Optional DEC_KS_SELFCHECK_EN: adds selfcheck_err, set when the unwound state differs from the loaded key/delta.
module dec_key_schedule_128 #(
  parameter int unsigned          KEY_SIZE   = 128,
  parameter int unsigned          SIDE_SIZE  = 64,
  parameter int unsigned          PD         = 56,
  parameter logic [SIDE_SIZE-1:0] DELTA0     = 64'h9e3779b97f4a7c15,
  parameter logic [SIDE_SIZE-1:0] DELTA_INIT = 64'h0,
  parameter int unsigned          ROUNDS     = 48
) (
  input logic                   clk,
  input logic                   rst,
  dec_key_schedule_128_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRECOMP, EMIT} state_t;

  localparam logic [5:0] LAST_PRE = 6'(ROUNDS - 1);

  state_t               state;
  logic [0:KEY_SIZE-1]  key_r;
  logic [SIDE_SIZE-1:0] delta_r;
  logic [5:0]           cnt;
  logic                 busy_r;
  logic                 valid_r;
  logic                 done_r;

  logic [0:KEY_SIZE-1]  k0_fwd, key_fwd, k0_inv, key_inv;
  logic [SIDE_SIZE-1:0] delta_fwd, delta_inv, sk_fwd, low_inv;

  // Forward step E and its exact inverse D, both evaluated from the current state.
  always_comb begin
    delta_fwd = delta_r + DELTA0;
    k0_fwd    = {key_r[KEY_SIZE-PD:KEY_SIZE-1], key_r[0:KEY_SIZE-PD-1]};
    sk_fwd    = k0_fwd[SIDE_SIZE:KEY_SIZE-1] + delta_fwd;
    key_fwd   = {k0_fwd[0:SIDE_SIZE-1], sk_fwd};

    low_inv   = key_r[SIDE_SIZE:KEY_SIZE-1] - delta_r;
    k0_inv    = {key_r[0:SIDE_SIZE-1], low_inv};
    key_inv   = {k0_inv[PD:KEY_SIZE-1], k0_inv[0:PD-1]};
    delta_inv = delta_r - DELTA0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      key_r   <= '0;
      delta_r <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            key_r   <= bus.key_in;
            delta_r <= DELTA_INIT;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= PRECOMP;
          end
        end
        PRECOMP: begin
          key_r   <= key_fwd;
          delta_r <= delta_fwd;
          cnt     <= cnt + 6'd1;
          if (cnt == LAST_PRE) begin
            valid_r <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (bus.sk_ready) begin
            key_r   <= key_inv;
            delta_r <= delta_inv;
            cnt     <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The subkey is the low half of the held state, so it cannot depend on sk_ready.
  assign bus.sk       = key_r[SIDE_SIZE:KEY_SIZE-1];
  assign bus.sk_round = cnt;
  assign bus.sk_valid = valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

`ifdef DEC_KS_SELFCHECK_EN
  logic [0:KEY_SIZE-1] key_copy;
  logic                err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_copy <= '0;
      err_r    <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      key_copy <= bus.key_in;
      err_r    <= 1'b0;
    end else if (state == EMIT && bus.sk_ready && cnt == 6'd1 &&
                 (key_inv != key_copy || delta_inv != DELTA_INIT)) begin
      err_r <= 1'b1;
    end
  end

  assign bus.selfcheck_err = err_r;
`endif

endmodule

// File: tb/tb_dec_key_schedule_128.sv
// Bench for dec_key_schedule_128: three instances (ROUNDS 1, 2, 48) checked by a scoreboard
// fed from a forward-only schedule model; a single monitor process does all comparisons.
module tb_dec_key_schedule_128;

  localparam int N = 3;
  localparam int RND [N] = '{1, 2, 48};
  localparam logic [63:0] D0 = 64'h9e3779b97f4a7c15;

  typedef struct packed {
    logic [5:0]  rnd;
    logic [63:0] sk;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]        start, sk_ready, busy, sk_valid, done, sc_err;
  logic [N-1:0][127:0] key_in;
  logic [N-1:0][63:0]  sk;
  logic [N-1:0][5:0]   sk_round;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dec_key_schedule_128_if bus ();
    assign bus.start    = start[g];
    assign bus.key_in   = key_in[g];
    assign bus.sk_ready = sk_ready[g];
    assign busy[g]      = bus.busy;
    assign sk_valid[g]  = bus.sk_valid;
    assign done[g]      = bus.done;
    assign sk[g]        = bus.sk;
    assign sk_round[g]  = bus.sk_round;
`ifdef DEC_KS_SELFCHECK_EN
    assign sc_err[g]    = bus.selfcheck_err;
`else
    assign sc_err[g]    = 1'b0;
`endif
    dec_key_schedule_128 #(.ROUNDS(RND[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Scoreboard queues and requests for direct comparisons issued by the stimulus.
  exp_t         exp_q [N][$];
  string        name_q [$];
  logic [127:0] act_q [$];
  logic [127:0] ref_q [$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic req(input string name, input logic [127:0] act, input logic [127:0] exp);
    name_q.push_back(name);
    act_q.push_back(act);
    ref_q.push_back(exp);
  endtask

  function automatic logic [127:0] outs(input int g);
    return 128'({busy[g], sk_valid[g], done[g], sk_round[g], sk[g]});
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: run the encryption schedule forward as plain 128-bit arithmetic, then queue subkeys last-first.
  task automatic push_model(input int g, input logic [127:0] key);
    logic [63:0]  subs [64];
    logic [127:0] k, k0;
    logic [63:0]  d;
    k = key;
    d = 64'h0;
    for (int i = 1; i <= RND[g]; i++) begin
      d  = d + D0;
      k0 = (k >> 56) | (k << 72);
      k  = {k0[127:64], k0[63:0] + d};
      subs[i] = k[63:0];
    end
    for (int i = RND[g]; i >= 1; i--) exp_q[g].push_back({6'(i), subs[i]});
  endtask

  task automatic push_exp(input int g, input logic [63:0] s, input logic [5:0] r);
    exp_q[g].push_back({r, s});
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  logic [N-1:0] hold_pend = '0;
  logic [63:0]  held_sk  [N];
  logic [5:0]   held_rnd [N];

  always @(negedge clk) begin
    while (name_q.size() != 0) check(name_q.pop_front(), act_q.pop_front(), ref_q.pop_front());
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        hold_pend[g] <= 1'b0;
      end else begin
        if (hold_pend[g])
          check("stall_hold", 128'({sk_valid[g], sk_round[g], sk[g]}),
                128'({1'b1, held_rnd[g], held_sk[g]}));
        hold_pend[g] <= sk_valid[g] && !sk_ready[g];
        held_sk[g]   <= sk[g];
        held_rnd[g]  <= sk_round[g];
        if (sk_valid[g] && sk_ready[g]) begin
          exp_t e;
          e = (exp_q[g].size() != 0) ? exp_q[g].pop_front() : '1;
          check("subkey", 128'({sk_round[g], sk[g]}), 128'(e));
        end
        if (done[g])
          check("done_state", 128'({busy[g], sk_valid[g], sc_err[g], 8'(exp_q[g].size())}), 128'(0));
      end
    end
  end

  task automatic run_seq(input int g, input logic [127:0] key, input int stall, input bit ign,
                         input bit use_model);
    int lat;
    int cyc;
    if (use_model) push_model(g, key);
    sk_ready[g] = 1'b1;
    key_in[g]   = key;
    start[g]    = 1'b1;
    @(posedge clk); #1;
    start[g]  = 1'b0;
    key_in[g] = rand_key();
    lat = 1;
    while (!sk_valid[g] && lat <= RND[g] + 4) begin
      start[g] = ign && (lat == 1);
      @(posedge clk); #1;
      lat++;
    end
    start[g] = 1'b0;
    req("first_valid_latency", 128'(lat), 128'(RND[g] + 1));
    cyc = 0;
    while (!done[g] && cyc < 3000) begin
      sk_ready[g] = ($urandom_range(99) >= stall);
      start[g]    = ign && (cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start[g]    = 1'b0;
    sk_ready[g] = 1'b0;
    req("done_seen", 128'(done[g]), 128'(1));
    @(posedge clk); #1;
    req("done_one_cycle", 128'({done[g], busy[g]}), 128'(0));
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    for (int g = 0; g < N; g++) exp_q[g].delete();
    @(posedge clk); #1;
    for (int g = 0; g < N; g++) req(name, outs(g), 128'(0));
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = '0;
    sk_ready = '0;
    key_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) req("reset_state", outs(g), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    push_exp(0, 64'h9e3779b97f4a7c15, 6'd1);
    run_seq(0, 128'h0, 0, 1'b0, 1'b0);
    push_exp(1, 64'h3c6ef372fe94f8c8, 6'd2);
    push_exp(1, 64'h9e3779b97f4a7c15, 6'd1);
    run_seq(1, 128'h0, 0, 1'b0, 1'b0);

    run_seq(2, rand_key(), 0, 1'b0, 1'b1);
    run_seq(2, rand_key(), 40, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) run_seq(i % 2, rand_key(), 50, 1'b0, 1'b1);

    // Reset in the middle of PRECOMP.
    key_in[2] = rand_key();
    start[2]  = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    pulse_reset("reset_mid_precomp");

    // Reset in the middle of EMIT, with the partial stream still checked.
    key_in[2] = rand_key();
    push_model(2, key_in[2]);
    sk_ready[2] = 1'b0;
    start[2]    = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    for (int i = 0; i < 100 && !sk_valid[2]; i++) begin
      @(posedge clk); #1;
    end
    req("emit_reached", 128'(sk_valid[2]), 128'(1));
    for (int i = 0; i < 10; i++) begin
      sk_ready[2] = $urandom_range(1);
      @(posedge clk); #1;
    end
    sk_ready[2] = 1'b0;
    pulse_reset("reset_mid_emit");

    run_seq(2, rand_key(), 30, 1'b0, 1'b1);

    for (int g = 0; g < N; g++) req("queue_drained", 128'(exp_q[g].size()), 128'(0));
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
